// File: rtl/projectile_pool.sv
// Pool of N_SLOTS vertical projectiles: lowest-free-slot spawn, per-frame motion, retire at limit or on hit.
// Latency: spawn/move/hit take effect at the next clock edge; count and spawn_ready are combinational.
// Backpressure: spawn_ready drops when all slots are busy, on done, or while cooling (PROJ_POOL_COOLDOWN_EN).
module projectile_pool #(
   parameter int N_SLOTS         = 3,
   parameter int W               = 10,
   parameter int SPEED           = 2,
   parameter bit DIR_DOWN        = 1'b1,
   parameter int Y_LIMIT         = 479,
   parameter int COOLDOWN_FRAMES = 30,
   localparam int CW             = $clog2(N_SLOTS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arst,
   input  logic                 frame,
   input  logic                 done,
   input  logic                 spawn_valid,
   output logic                 spawn_ready,
   input  logic [W-1:0]         spawn_x,
   input  logic [W-1:0]         spawn_y,
   input  logic [N_SLOTS-1:0]   hit,
   output logic [N_SLOTS-1:0]   active,
   output logic [N_SLOTS*W-1:0] proj_x,
   output logic [N_SLOTS*W-1:0] proj_y,
   output logic [CW-1:0]        count
);

   logic [N_SLOTS-1:0] free_mask;
   logic [N_SLOTS-1:0] alloc_oh;
   logic               cd_zero;
   logic               accept;
   logic               move;

   // Isolating the lowest set bit of the free mask picks the lowest-index free slot.
   assign free_mask   = ~active;
   assign alloc_oh    = free_mask & (~free_mask + N_SLOTS'(1));
   assign spawn_ready = (|free_mask) & ~done & cd_zero;
   assign accept      = spawn_valid & spawn_ready;
   assign move        = frame & ~done;

`ifdef PROJ_POOL_COOLDOWN_EN
   localparam int DW = ($clog2(COOLDOWN_FRAMES + 1) < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
   logic [DW-1:0] cd_cnt;

   // A load on accept beats a decrement from a coincident frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cd_cnt <= '0;
      end else if (arst) begin
         cd_cnt <= '0;
      end else if (accept) begin
         cd_cnt <= DW'(COOLDOWN_FRAMES);
      end else if (move && (cd_cnt != '0)) begin
         cd_cnt <= cd_cnt - DW'(1);
      end
   end

   assign cd_zero = (cd_cnt == '0);
`else
   assign cd_zero = 1'b1;
`endif

   logic [W-1:0]       y_cur  [N_SLOTS];
   logic [W:0]         y_down [N_SLOTS];
   logic [W-1:0]       y_next [N_SLOTS];
   logic [N_SLOTS-1:0] limit_hit;

   // Downward sum is one bit wider so a step past the top of the coordinate range still retires.
   always_comb begin
      limit_hit = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         y_cur[i]  = proj_y[i*W +: W];
         y_down[i] = {1'b0, y_cur[i]} + (W+1)'(SPEED);
         if (DIR_DOWN) begin
            limit_hit[i] = (y_down[i] > (W+1)'(Y_LIMIT));
            y_next[i]    = y_down[i][W-1:0];
         end else begin
            limit_hit[i] = (y_cur[i] < W'(SPEED));
            y_next[i]    = y_cur[i] - W'(SPEED);
         end
      end
   end

   // Per slot: hit beats move beats spawn; a spawning slot is inactive so it never also moves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active <= '0;
         proj_x <= '0;
         proj_y <= '0;
      end else if (arst) begin
         active <= '0;
         proj_x <= '0;
         proj_y <= '0;
      end else begin
         for (int i = 0; i < N_SLOTS; i++) begin
            if (hit[i] && active[i]) begin
               active[i] <= 1'b0;
            end else if (active[i] && move) begin
               if (limit_hit[i]) begin
                  active[i] <= 1'b0;
               end else begin
                  proj_y[i*W +: W] <= y_next[i];
               end
            end else if (accept && alloc_oh[i]) begin
               active[i]        <= 1'b1;
               proj_x[i*W +: W] <= spawn_x;
               proj_y[i*W +: W] <= spawn_y;
            end
         end
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         count = count + CW'(active[i]);
      end
   end

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: a downward pool and an upward pool share stimulus and are both scored
// against an array-based behavioural model; cooldown scenario runs when PROJ_POOL_COOLDOWN_EN is defined.
module tb_projectile_pool;
   localparam int N    = 3;
   localparam int W    = 10;
   localparam int SPD  = 2;
   localparam int YLIM = 479;
   localparam int CDF  = 2;
`ifdef PROJ_POOL_COOLDOWN_EN
   localparam bit CD_EN = 1'b1;
`else
   localparam bit CD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, arst, frame, done, spawn_valid;
   logic [W-1:0] spawn_x, spawn_y;
   logic [N-1:0] hit;

   logic         rdy_o [2];
   logic [N-1:0] act_o [2];
   logic [N*W-1:0] px_o [2];
   logic [N*W-1:0] py_o [2];
   logic [1:0]   cnt_o [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   projectile_pool #(.N_SLOTS(N), .W(W), .SPEED(SPD), .DIR_DOWN(1'b1), .Y_LIMIT(YLIM),
                     .COOLDOWN_FRAMES(CDF)) dut_dn (
      .clk(clk), .rst(rst), .arst(arst), .frame(frame), .done(done),
      .spawn_valid(spawn_valid), .spawn_ready(rdy_o[0]), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .hit(hit), .active(act_o[0]), .proj_x(px_o[0]), .proj_y(py_o[0]), .count(cnt_o[0]));

   projectile_pool #(.N_SLOTS(N), .W(W), .SPEED(SPD), .DIR_DOWN(1'b0), .Y_LIMIT(YLIM),
                     .COOLDOWN_FRAMES(CDF)) dut_up (
      .clk(clk), .rst(rst), .arst(arst), .frame(frame), .done(done),
      .spawn_valid(spawn_valid), .spawn_ready(rdy_o[1]), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .hit(hit), .active(act_o[1]), .proj_x(px_o[1]), .proj_y(py_o[1]), .count(cnt_o[1]));

   // Reference model: pool 0 moves down, pool 1 moves up.
   bit m_act  [2][N];
   bit m_zero [2][N];
   int m_x    [2][N];
   int m_y    [2][N];
   int m_cd   [2];

   function automatic void model_clear();
      for (int p = 0; p < 2; p++) begin
         m_cd[p] = 0;
         for (int i = 0; i < N; i++) begin
            m_act[p][i] = 0; m_zero[p][i] = 1; m_x[p][i] = 0; m_y[p][i] = 0;
         end
      end
   endfunction

   function automatic bit exp_rdy(int p);
      bit any_free = 0;
      for (int i = 0; i < N; i++) if (!m_act[p][i]) any_free = 1;
      return any_free && !done && (!CD_EN || m_cd[p] == 0);
   endfunction

   function automatic int exp_cnt(int p);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_act[p][i]);
      return c;
   endfunction

   function automatic logic [N-1:0] exp_act(int p);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_act[p][i];
      return r;
   endfunction

   function automatic logic [N*W-1:0] exp_pos(int p, bit want_y);
      logic [N*W-1:0] r;
      for (int i = 0; i < N; i++) r[i*W +: W] = W'(want_y ? m_y[p][i] : m_x[p][i]);
      return r;
   endfunction

   // Positions are only meaningful for live slots or slots freshly cleared by reset.
   function automatic logic [N*W-1:0] pos_mask(int p);
      logic [N*W-1:0] r = '0;
      for (int i = 0; i < N; i++) if (m_act[p][i] || m_zero[p][i]) r[i*W +: W] = '1;
      return r;
   endfunction

   function automatic void model_edge();
      for (int p = 0; p < 2; p++) begin
         bit acc   = spawn_valid && exp_rdy(p);
         int alloc = -1;
         for (int i = N - 1; i >= 0; i--) if (!m_act[p][i]) alloc = i;
         if (arst) begin
            m_cd[p] = 0;
            for (int i = 0; i < N; i++) begin
               m_act[p][i] = 0; m_zero[p][i] = 1; m_x[p][i] = 0; m_y[p][i] = 0;
            end
         end else begin
            for (int i = 0; i < N; i++) begin
               if (hit[i] && m_act[p][i]) m_act[p][i] = 0;
               else if (m_act[p][i] && frame && !done) begin
                  if (p == 0) begin
                     if (m_y[p][i] + SPD > YLIM) m_act[p][i] = 0;
                     else m_y[p][i] += SPD;
                  end else begin
                     if (m_y[p][i] < SPD) m_act[p][i] = 0;
                     else m_y[p][i] -= SPD;
                  end
               end else if (acc && i == alloc) begin
                  m_act[p][i] = 1; m_zero[p][i] = 0;
                  m_x[p][i] = int'(spawn_x); m_y[p][i] = int'(spawn_y);
               end
            end
            if (acc) m_cd[p] = CDF;
            else if (frame && !done && m_cd[p] > 0) m_cd[p]--;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      arst = 0; frame = 0; done = 0; spawn_valid = 0; hit = '0;
   endtask

   task automatic restart();
      idle(); arst = 1; tick(); arst = 0;
   endtask

   task automatic test_reset();
      rst = 0; idle(); spawn_x = '0; spawn_y = '0;
      model_clear();
      #12;
      for (int p = 0; p < 2; p++) begin
         n_tests++; if (act_o[p] !== '0) begin n_fail++; $display("FAIL reset_active pool%0d got %b want 0", p, act_o[p]); end
         n_tests++; if (px_o[p] !== '0 || py_o[p] !== '0) begin n_fail++; $display("FAIL reset_pos pool%0d got %h/%h want 0", p, px_o[p], py_o[p]); end
         n_tests++; if (rdy_o[p] !== 1'b1) begin n_fail++; $display("FAIL reset_ready pool%0d got %b want 1", p, rdy_o[p]); end
         n_tests++; if (cnt_o[p] !== 2'd0) begin n_fail++; $display("FAIL reset_count pool%0d got %0d want 0", p, cnt_o[p]); end
      end
      @(posedge clk); #1; rst = 1;
   endtask

   task automatic test_fill();
      logic [N-1:0] seq [4];
      seq = '{3'b001, 3'b011, 3'b111, 3'b111};
      restart();
      spawn_valid = 1; spawn_x = 10'd100; spawn_y = 10'd50;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (k == 3) begin
            n_tests++; if (rdy_o[0] !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full got %b want 0", rdy_o[0]); end
         end
         tick();
         n_tests++; if (act_o[0] !== seq[k]) begin n_fail++; $display("FAIL fill_active step%0d got %b want %b", k, act_o[0], seq[k]); end
      end
      n_tests++; if (cnt_o[0] !== 2'd3) begin n_fail++; $display("FAIL fill_count got %0d want 3", cnt_o[0]); end
      n_tests++; if (py_o[1] !== {3{10'd50}}) begin n_fail++; $display("FAIL fill_pos got %h want all 50", py_o[1]); end
      spawn_valid = 0;
   endtask

   task automatic test_down_retire();
      restart();
      spawn_valid = 1; spawn_x = 10'd200; spawn_y = 10'd476; tick(); spawn_valid = 0;
      frame = 1; tick();
      n_tests++; if (py_o[0][W-1:0] !== 10'd478 || act_o[0][0] !== 1'b1) begin n_fail++; $display("FAIL down_move got y=%0d act=%b want y=478 act=1", py_o[0][W-1:0], act_o[0][0]); end
      n_tests++; if (py_o[1][W-1:0] !== 10'd474) begin n_fail++; $display("FAIL up_move_far got %0d want 474", py_o[1][W-1:0]); end
      tick(); frame = 0;
      n_tests++; if (act_o[0][0] !== 1'b0 || cnt_o[0] !== 2'd0) begin n_fail++; $display("FAIL down_retire got act=%b cnt=%0d want 0/0", act_o[0][0], cnt_o[0]); end
      n_tests++; if (act_o[1][0] !== 1'b1) begin n_fail++; $display("FAIL up_still_live got %b want 1", act_o[1][0]); end
   endtask

   task automatic test_hit_frame();
      restart();
      spawn_valid = 1; spawn_x = 10'd20; spawn_y = 10'd50;
      repeat (3) tick();
      hit = 3'b010; frame = 1; tick();
      hit = '0; frame = 0;
      n_tests++; if (act_o[0] !== 3'b101) begin n_fail++; $display("FAIL hit_clear got %b want 101", act_o[0]); end
      n_tests++; if (py_o[0][W +: W] !== 10'd50 || py_o[0][0 +: W] !== 10'd52) begin n_fail++; $display("FAIL hit_nomove got %h want slot1=50 slot0=52", py_o[0]); end
      spawn_y = 10'd300; tick(); spawn_valid = 0;
      n_tests++; if (act_o[0] !== 3'b111 || py_o[0][W +: W] !== 10'd300) begin n_fail++; $display("FAIL hit_reuse got act=%b y1=%0d want 111/300", act_o[0], py_o[0][W +: W]); end
   endtask

   task automatic test_up();
      restart();
      spawn_valid = 1; spawn_x = 10'd7; spawn_y = 10'd3; tick(); spawn_valid = 0;
      frame = 1; tick();
      n_tests++; if (py_o[1][W-1:0] !== 10'd1 || act_o[1][0] !== 1'b1) begin n_fail++; $display("FAIL up_step got y=%0d act=%b want 1/1", py_o[1][W-1:0], act_o[1][0]); end
      tick(); frame = 0;
      n_tests++; if (act_o[1][0] !== 1'b0) begin n_fail++; $display("FAIL up_retire got %b want 0", act_o[1][0]); end
      n_tests++; if (px_o[0][W-1:0] !== 10'd7 || py_o[0][W-1:0] !== 10'd7) begin n_fail++; $display("FAIL down_xy got %0d,%0d want 7,7", px_o[0][W-1:0], py_o[0][W-1:0]); end
   endtask

   task automatic test_freeze();
      done = 1; frame = 1; spawn_valid = 1; spawn_y = 10'd9;
      repeat (5) tick();
      n_tests++; if (py_o[0][W-1:0] !== 10'd7 || act_o[0] !== 3'b001) begin n_fail++; $display("FAIL freeze_hold got y=%0d act=%b want 7/001", py_o[0][W-1:0], act_o[0]); end
      n_tests++; if (rdy_o[0] !== 1'b0 || rdy_o[1] !== 1'b0) begin n_fail++; $display("FAIL freeze_ready got %b%b want 00", rdy_o[0], rdy_o[1]); end
      hit = 3'b001; tick(); hit = '0;
      n_tests++; if (act_o[0] !== 3'b000) begin n_fail++; $display("FAIL freeze_hit got %b want 000", act_o[0]); end
      idle();
   endtask

   task automatic test_arst();
      spawn_valid = 1; spawn_x = 10'd33; spawn_y = 10'd44; tick(); tick();
      arst = 1; frame = 1; hit = 3'b111; tick(); idle();
      for (int p = 0; p < 2; p++) begin
         n_tests++; if (act_o[p] !== '0 || px_o[p] !== '0 || py_o[p] !== '0) begin n_fail++; $display("FAIL arst_clear pool%0d got act=%b x=%h y=%h want 0", p, act_o[p], px_o[p], py_o[p]); end
      end
   endtask

   task automatic test_async_rst();
      spawn_valid = 1; spawn_x = 10'd5; spawn_y = 10'd6; tick(); spawn_valid = 0;
      #2 rst = 0; model_clear();
      #1;
      for (int p = 0; p < 2; p++) begin
         n_tests++; if (act_o[p] !== '0 || px_o[p] !== '0 || py_o[p] !== '0 || cnt_o[p] !== 2'd0 || rdy_o[p] !== 1'b1) begin
            n_fail++; $display("FAIL async_rst pool%0d got act=%b x=%h y=%h cnt=%0d rdy=%b", p, act_o[p], px_o[p], py_o[p], cnt_o[p], rdy_o[p]);
         end
      end
      #2 rst = 1;
      tick();
   endtask

   task automatic test_cooldown();
      restart();
      spawn_valid = 1; tick(); spawn_valid = 0;
      n_tests++; if (rdy_o[0] !== 1'b0) begin n_fail++; $display("FAIL cd_after_accept got %b want 0", rdy_o[0]); end
      frame = 1; tick(); frame = 0;
      n_tests++; if (rdy_o[0] !== 1'b0) begin n_fail++; $display("FAIL cd_one_frame got %b want 0", rdy_o[0]); end
      frame = 1; tick(); frame = 0;
      n_tests++; if (rdy_o[0] !== 1'b1) begin n_fail++; $display("FAIL cd_two_frames got %b want 1", rdy_o[0]); end
      spawn_valid = 1; frame = 1; tick(); spawn_valid = 0; frame = 0;
      n_tests++; if (rdy_o[0] !== 1'b0) begin n_fail++; $display("FAIL cd_coinc_load got %b want 0", rdy_o[0]); end
      frame = 1; tick(); frame = 0;
      n_tests++; if (rdy_o[0] !== 1'b0) begin n_fail++; $display("FAIL cd_coinc_one got %b want 0", rdy_o[0]); end
      frame = 1; tick(); frame = 0;
      n_tests++; if (rdy_o[0] !== 1'b1) begin n_fail++; $display("FAIL cd_coinc_two got %b want 1", rdy_o[0]); end
   endtask

   task automatic test_random();
      restart();
      for (int c = 0; c < 600; c++) begin
         arst        = ($urandom_range(0, 99) == 0);
         frame       = ($urandom_range(0, 2) == 0);
         done        = ($urandom_range(0, 11) == 0);
         spawn_valid = $urandom_range(0, 1) == 1;
         hit         = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         spawn_x     = W'($urandom);
         case ($urandom_range(0, 2))
            0:       spawn_y = W'($urandom_range(0, 5));
            1:       spawn_y = W'($urandom_range(YLIM - 5, YLIM));
            default: spawn_y = W'($urandom_range(0, YLIM));
         endcase
         #1;
         for (int p = 0; p < 2; p++) begin
            n_tests++; if (rdy_o[p] !== exp_rdy(p)) begin n_fail++; $display("FAIL rand_ready pool%0d cyc%0d got %b want %b", p, c, rdy_o[p], exp_rdy(p)); end
            n_tests++; if (cnt_o[p] !== 2'(exp_cnt(p))) begin n_fail++; $display("FAIL rand_count pool%0d cyc%0d got %0d want %0d", p, c, cnt_o[p], exp_cnt(p)); end
         end
         tick();
         for (int p = 0; p < 2; p++) begin
            n_tests++; if (act_o[p] !== exp_act(p)) begin n_fail++; $display("FAIL rand_active pool%0d cyc%0d got %b want %b", p, c, act_o[p], exp_act(p)); end
            n_tests++; if ((px_o[p] & pos_mask(p)) !== (exp_pos(p, 0) & pos_mask(p))) begin n_fail++; $display("FAIL rand_x pool%0d cyc%0d got %h want %h", p, c, px_o[p] & pos_mask(p), exp_pos(p, 0) & pos_mask(p)); end
            n_tests++; if ((py_o[p] & pos_mask(p)) !== (exp_pos(p, 1) & pos_mask(p))) begin n_fail++; $display("FAIL rand_y pool%0d cyc%0d got %h want %h", p, c, py_o[p] & pos_mask(p), exp_pos(p, 1) & pos_mask(p)); end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_down_retire();
      test_hit_frame();
      test_up();
      test_freeze();
      test_arst();
      test_async_rst();
`ifdef PROJ_POOL_COOLDOWN_EN
      test_cooldown();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/projectile_pool.md
# projectile_pool

Parametrised pool of `N_SLOTS` independent vertical projectiles, the generalised successor to the game's fixed three-missile logic. Allocates a free slot on a spawn handshake and advances every active projectile once per video frame. Retires projectiles at the playfield limit or on a per-slot collision from the VGA controller. Sits between the entity blocks (invaders, player) that request shots and the `vga_controller`/`score_logic` pair that draw them and report hits.

## Interface

**Parameters**
- `N_SLOTS`, default 3: number of projectile slots (1–16).
- `W`, default 10: coordinate width in bits.
- `SPEED`, default 2: pixels moved per frame.
- `DIR_DOWN`, default 1: 1 moves toward larger y (invader missiles); 0 moves toward smaller y (player lasers).
- `Y_LIMIT`, default 479: last visible row when moving down. Moving up, the limit is row 0.
- `COOLDOWN_FRAMES`, default 30: minimum frames between accepted spawns (only with `PROJ_POOL_COOLDOWN_EN`).

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: **asynchronous, active-low** reset.
- `arst` in 1: synchronous game-restart clear, active-high, from the debouncer.
- `frame` in 1: one-cycle pulse per video frame.
- `done` in 1: game over; freezes the pool.
- `spawn_valid` in 1: spawn request.
- `spawn_ready` out 1: pool can accept a spawn this cycle.
- `spawn_x`, `spawn_y` in W each: initial position, sampled on accept.
- `hit` in N_SLOTS: per-slot collision flags.
- `active` out N_SLOTS: slot-occupied mask.
- `proj_x`, `proj_y` out N_SLOTS*W each: packed positions, slot i at `[i*W +: W]`.
- `count` out $clog2(N_SLOTS+1): popcount of `active`.

## Operation

- **Reset** (`rst`=0): `active`=0, all `proj_x`/`proj_y`=0, cooldown counter=0. After reset, `spawn_ready`=1 and `count`=0.
- **`arst`**: same clear as reset, applied synchronously. It has priority over all other inputs.
- **`spawn_ready`** = (any slot free) & !`done` & (cooldown counter==0). It is combinational.
- **Accept**: `spawn_valid & spawn_ready`.
  - Allocates the lowest-index free slot.
  - Loads `spawn_x`/`spawn_y` into that slot and sets its `active` bit.
- **Move**: on `frame` with !`done`, each active slot that was not spawned this cycle updates y.
  - Down: y+SPEED, computed at W+1 bits. If the result is greater than `Y_LIMIT`, the slot deactivates.
  - Up: if y < SPEED, the slot deactivates; otherwise y−SPEED.
  - x never changes after spawn.
  - On deactivation, x and y hold their last values; they are don't-care while the slot is inactive.
- **Hit**: `hit[i]` with `active[i]` clears `active[i]`. It applies even when `done`=1. `hit` on an inactive slot is ignored.
- **Same-cycle priority per slot** (highest first): `arst` > hit > move > spawn.
  - A slot freed by hit this cycle is not reusable until the next cycle, because allocation uses the pre-edge `active`.
  - Spawn and `frame` in the same cycle: the new slot does not move on that frame.
- **`done`=1**: positions frozen, `spawn_ready`=0, cooldown counter frozen.

## Timing

- A spawn accepted at edge k has `active`, `proj_x` and `proj_y` valid after edge k; latency 1 cycle.
- A move or retire triggered by `frame` high in cycle k takes effect at edge k.
- A hit in cycle k clears `active` at edge k.
- All outputs except `spawn_ready` and `count` are registered.
- At most one spawn is accepted per cycle.

## Configuration

- **`PROJ_POOL_COOLDOWN_EN` defined**:
  - On accept, the cooldown counter loads `COOLDOWN_FRAMES`.
  - It decrements by 1 on each `frame` while nonzero.
  - `spawn_ready` requires counter==0.
  - If accept and `frame` fall in the same cycle, the load wins.
- **Undefined**: no counter is built; the counter==0 term is constant 1, so spawns are limited only by free slots.

## Test plan

- **Fill and exhaust**: reset; hold `spawn_valid` with spawn=(100,50) for 4 cycles, cooldown off, N_SLOTS=3 → `active` 001, 011, 111; `spawn_ready`=0 on the 4th cycle; `count`=3.
- **Down retire**: slot 0 at y=476, SPEED=2, Y_LIMIT=479 → after frame 1 y=478 and active; after frame 2 the slot is inactive; `count` decrements.
- **Hit/frame collision**: `hit[1]`=1 and `frame`=1 in the same cycle → `active[1]`=0 and no move. Spawn in the next cycle reuses slot 1, the lowest free.
- **Up direction**: DIR_DOWN=0, spawn y=3, SPEED=2 → y=1 after frame 1; retired on frame 2.
- **Cooldown** (macro defined, COOLDOWN_FRAMES=2): accept → `spawn_ready`=0 for exactly 2 frame pulses, then 1. Accept coincident with `frame` → still 2 frames.
- **Freeze and resets**: `done`=1 → positions hold over 5 frames, `spawn_ready`=0, `hit` still clears. `arst` pulse → `active`=0, positions 0. `rst` low mid-operation → same values immediately, without waiting for a clock edge.
